// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and byte-lane helpers for the SRAM controller.
// Lanes are little-endian: byte lane i is data bits [8i+7:8i].
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } resp_state_t;

    function automatic logic [3:0] size_to_wbe(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] wbe;
        case (hsize)
            HSIZE_BYTE: wbe = 4'b0001 << addr;
            HSIZE_HALF: wbe = 4'b0011 << addr;
            default:    wbe = 4'b1111;
        endcase
        return wbe;
    endfunction

    function automatic logic is_unaligned(input logic [2:0] hsize, input logic [1:0] addr);
        return ((hsize == HSIZE_HALF) && addr[0]) ||
               ((hsize == HSIZE_WORD) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer: parks a write that lost the SRAM port to a read,
// and patches its bytes into read data for the same word until it drains.
module ahb_sram_wbuf #(
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 drain,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [3:0]           load_wbe,
    input  logic [31:0]          load_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [31:0]          sram_dout,
    output logic                 buf_valid,
    output logic [ADDR_BITS-1:0] buf_addr,
    output logic [3:0]           buf_wbe,
    output logic [31:0]          buf_data,
    output logic [31:0]          rd_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_wbe   <= '0;
            buf_data  <= '0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_addr  <= load_addr;
            buf_wbe   <= load_wbe;
            buf_data  <= load_data;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

    // The SRAM copy is stale for any lane the buffer still owns.
    always_comb begin
        rd_data = sram_dout;
        if (buf_valid && (buf_addr == rd_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (buf_wbe[i]) begin
                    rd_data[8*i +: 8] = buf_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave driving a single-port SRAM with zero wait states; writes that
// collide with a read address phase are parked in a one-entry buffer.
//
// state   | meaning
// ST_OKAY | normal zero-wait OKAY responses
// ST_ERR1 | first ERROR cycle, hreadyout=0
// ST_ERR2 | second ERROR cycle, hreadyout=1, new address phase may be taken
module ahb_sram_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_BITS   = 7,
    parameter int ADDR_AMOUNT = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hsel,
    input  logic [31:0]          haddr,
    input  logic [1:0]           htrans,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [31:0]          hwdata,
    input  logic                 hready,
    output logic                 hreadyout,
    output logic                 hresp,
    output logic [31:0]          hrdata,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [3:0]           sram_wbe,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [31:0]          sram_din,
    input  logic [31:0]          sram_dout
);

    localparam logic [31:0] AMOUNT_W = 32'(ADDR_AMOUNT);

    resp_state_t          state_q, state_d;
    logic                 accept, bad, rd_acc, wr_acc;
    logic [ADDR_BITS-1:0] idx;
    logic                 wr_dp, rd_dp;
    logic [ADDR_BITS-1:0] wr_addr, rd_addr;
    logic [3:0]           wr_wbe;
    logic [31:0]          hrdata_q, merged;
    logic                 buf_valid, buf_load, buf_drain;
    logic [ADDR_BITS-1:0] buf_addr;
    logic [3:0]           buf_wbe;
    logic [31:0]          buf_data;
    logic                 unused_htrans;

    assign unused_htrans = htrans[0];
    assign idx = haddr[ADDR_BITS+1:2];

    // Range check uses the full word index so aliases above the array also fault.
    assign bad = (hsize > HSIZE_WORD) || is_unaligned(hsize, haddr[1:0]) ||
                 ({2'b00, haddr[31:2]} >= AMOUNT_W);
    assign accept = rst_n && hsel && hready && htrans[1];
    assign rd_acc = accept && !hwrite && !bad;
    assign wr_acc = accept && hwrite && !bad;

    assign buf_load  = wr_dp && rd_acc;
    assign buf_drain = buf_valid && !rd_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OKAY;
            wr_dp    <= 1'b0;
            rd_dp    <= 1'b0;
            wr_addr  <= '0;
            wr_wbe   <= '0;
            rd_addr  <= '0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_dp   <= wr_acc;
            rd_dp   <= rd_acc;
            if (wr_acc) begin
                wr_addr <= idx;
                wr_wbe  <= size_to_wbe(hsize, haddr[1:0]);
            end
            if (rd_acc) begin
                rd_addr <= idx;
            end
            if (rd_dp) begin
                hrdata_q <= merged;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_OKAY, ST_ERR2: state_d = (accept && bad) ? ST_ERR1 : ST_OKAY;
            ST_ERR1:          state_d = ST_ERR2;
            default:          state_d = ST_OKAY;
        endcase
        if (state_q == ST_ERR1) begin
            hreadyout = 1'b0;
        end
        if (state_q != ST_OKAY) begin
            hresp = HRESP_ERROR;
        end
    end

    // Port priority: read address phase, then buffer drain, then direct write.
    always_comb begin
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_wbe  = 4'b0000;
        sram_addr = '0;
        sram_din  = '0;
        if (rd_acc) begin
            sram_en   = 1'b1;
            sram_addr = idx;
        end else if (buf_valid) begin
            sram_en   = 1'b1;
            sram_we   = 1'b1;
            sram_wbe  = buf_wbe;
            sram_addr = buf_addr;
            sram_din  = buf_data;
        end else if (wr_dp) begin
            sram_en   = 1'b1;
            sram_we   = 1'b1;
            sram_wbe  = wr_wbe;
            sram_addr = wr_addr;
            sram_din  = hwdata;
        end
    end

    assign hrdata = rd_dp ? merged : hrdata_q;

    ahb_sram_wbuf #(
        .ADDR_BITS(ADDR_BITS)
    ) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .drain     (buf_drain),
        .load_addr (wr_addr),
        .load_wbe  (wr_wbe),
        .load_data (hwdata),
        .rd_addr   (rd_addr),
        .sram_dout (sram_dout),
        .buf_valid (buf_valid),
        .buf_addr  (buf_addr),
        .buf_wbe   (buf_wbe),
        .buf_data  (buf_data),
        .rd_data   (merged)
    );

    // The write address-phase cycle never uses the port, so it always drains.
    assert property (@(posedge clk) disable iff (!rst_n) !(wr_dp && buf_valid));

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl with a behavioural 1-cycle-read SRAM.
module tb_ahb_sram_ctrl;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        sram_en;
    logic        sram_we;
    logic [3:0]  sram_wbe;
    logic [6:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'd0;

    logic [31:0] mem [128];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahb_sram_ctrl #(
        .ADDR_BITS   (7),
        .ADDR_AMOUNT (128)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_wbe  (sram_wbe),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wbe[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [31:0] wbe, input logic [31:0] addr,
                            input logic [31:0] din);
        check_val({tag, "_en"},   32'(sram_en),   32'd1);
        check_val({tag, "_we"},   32'(sram_we),   32'd1);
        check_val({tag, "_wbe"},  32'(sram_wbe),  wbe);
        check_val({tag, "_addr"}, 32'(sram_addr), addr);
        check_val({tag, "_din"},  sram_din,       din);
    endtask

    task automatic check_rd(input string tag, input logic [31:0] addr);
        check_val({tag, "_en"},   32'(sram_en),   32'd1);
        check_val({tag, "_we"},   32'(sram_we),   32'd0);
        check_val({tag, "_addr"}, 32'(sram_addr), addr);
    endtask

    task automatic check_resp(input string tag, input logic [31:0] rdy, input logic [31:0] resp);
        check_val({tag, "_rdy"},  32'(hreadyout), rdy);
        check_val({tag, "_resp"}, 32'(hresp),     resp);
    endtask

    // One bus cycle: drive just after the rising edge, return at the falling edge.
    task automatic drive(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        hsel   = (tr != HTRANS_IDLE);
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hwdata = wd;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] wd);
        drive(HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wd);
    endtask

    initial begin
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD;
        haddr = 32'h10; hwdata = 32'h0;
        for (int i = 0; i < 128; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
        #1 rst_n = 1'b0;
        #2;
        check_resp("rst", 32'd1, 32'd0);
        check_val("rst_hrdata", hrdata, 32'h0);
        check_val("rst_en", 32'(sram_en), 32'd0);
        check_val("rst_addr", 32'(sram_addr), 32'd0);
        hsel = 1'b0; htrans = HTRANS_IDLE;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // word write, idle data phase, read back
        drive(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
        check_val("t1_aph_en", 32'(sram_en), 32'd0);
        idle(32'h11223344);
        check_wr("t1_direct", 32'hF, 32'd4, 32'h11223344);
        drive(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        check_rd("t1_rd", 32'd4);
        idle(32'h0);
        check_val("t1_hrdata", hrdata, 32'h11223344);
        check_resp("t1", 32'd1, 32'd0);

        // byte write then back-to-back read of the same word: merge and drain
        drive(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13, 32'h0);
        check_val("t2_aph_en", 32'(sram_en), 32'd0);
        drive(HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hAA000000);
        check_rd("t2_rd", 32'd4);
        idle(32'h0);
        check_val("t2_merge", hrdata, 32'hAA223344);
        check_wr("t2_drain", 32'h8, 32'd4, 32'hAA000000);
        idle(32'h0);
        check_val("t2_quiet_en", 32'(sram_en), 32'd0);
        check_val("t2_mem", mem[4], 32'hAA223344);

        // alternating W,R on 0x0..0xC, each read merges its preceding write
        for (int k = 0; k < 4; k++) begin
            drive(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(4*k), 32'h0);
            check_resp("t3_w", 32'd1, 32'd0);
            if (k > 0) begin
                check_val("t3_hrdata", hrdata, 32'(k));
                check_wr("t3_drain", 32'hF, 32'(k-1), 32'(k));
            end
            drive(HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'(4*k), 32'(k+1));
            check_resp("t3_r", 32'd1, 32'd0);
            check_rd("t3_rd", 32'(k));
        end
        idle(32'h0);
        check_val("t3_hrdata_last", hrdata, 32'd4);
        check_wr("t3_drain_last", 32'hF, 32'd3, 32'd4);
        idle(32'h0);
        check_val("t3_quiet_en", 32'(sram_en), 32'd0);
        for (int k = 0; k < 4; k++) check_val("t3_mem", mem[k], 32'(k+1));

        // misaligned half write: two-cycle ERROR, write offered in ERR1 ignored
        drive(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h01, 32'h0);
        check_resp("t4a_aph", 32'd1, 32'd0);
        check_val("t4a_aph_en", 32'(sram_en), 32'd0);
        drive(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0, 32'hFFFFFFFF);
        check_resp("t4a_err1", 32'd0, 32'd1);
        check_val("t4a_err1_en", 32'(sram_en), 32'd0);
        idle(32'h55555555);
        check_resp("t4a_err2", 32'd1, 32'd1);
        check_val("t4a_err2_en", 32'(sram_en), 32'd0);
        idle(32'h0);
        check_resp("t4a_after", 32'd1, 32'd0);
        check_val("t4a_after_en", 32'(sram_en), 32'd0);

        // word read beyond the implemented range
        drive(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h200, 32'h0);
        check_val("t4b_aph_en", 32'(sram_en), 32'd0);
        idle(32'h0);
        check_resp("t4b_err1", 32'd0, 32'd1);
        check_val("t4b_err1_en", 32'(sram_en), 32'd0);
        idle(32'h0);
        check_resp("t4b_err2", 32'd1, 32'd1);
        check_val("t4b_hrdata", hrdata, 32'd4);
        idle(32'h0);
        check_resp("t4b_after", 32'd1, 32'd0);
        check_val("t4_mem0", mem[0], 32'd1);

        // read then write of the same word: read sees the old value
        drive(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
        check_rd("t5_rd", 32'd8);
        drive(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
        check_val("t5_old", hrdata, 32'hC0DE0008);
        check_val("t5_aph_en", 32'(sram_en), 32'd0);
        idle(32'hDEADBEEF);
        check_wr("t5_direct", 32'hF, 32'd8, 32'hDEADBEEF);
        drive(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
        check_val("t5_mem", mem[8], 32'hDEADBEEF);
        idle(32'h0);
        check_val("t5_readback", hrdata, 32'hDEADBEEF);

        // reset while the buffer holds a write
        drive(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h24, 32'h0);
        drive(HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h28, 32'h12345678);
        check_rd("t6_rd", 32'd10);
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h0;
        #2;
        check_val("t6_hrdata", hrdata, 32'hC0DE000A);
        check_wr("t6_pending", 32'hF, 32'd9, 32'h12345678);
        rst_n = 1'b0;
        #1;
        check_resp("t6_rst", 32'd1, 32'd0);
        check_val("t6_rst_hrdata", hrdata, 32'h0);
        check_val("t6_rst_en", 32'(sram_en), 32'd0);
        check_val("t6_rst_we", 32'(sram_we), 32'd0);
        check_val("t6_rst_wbe", 32'(sram_wbe), 32'd0);
        check_val("t6_rst_addr", 32'(sram_addr), 32'd0);
        check_val("t6_rst_din", sram_din, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(32'h0);
        check_val("t6_post_en", 32'(sram_en), 32'd0);
        idle(32'h0);
        check_val("t6_post_en2", 32'(sram_en), 32'd0);
        check_val("t6_mem", mem[9], 32'hC0DE0009);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
